// File: rtl/bus_seq_pkg.sv
// Shared types and helpers for the bus scenario sequencer: FSM state encoding,
// step-entry field layout and a ceil-log2 helper.
package bus_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_NEXT  = 3'd4,
    ST_DONE  = 3'd5
  } seq_state_e;

  // Ceil log2, never below 1 so single-entry fields still get a bit.
  function automatic int unsigned seq_log2(input int unsigned v);
    int unsigned r;
    r = 1;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Entry layout, LSB first: data, addr, burst, read_en, mask, last.
  function automatic int unsigned seq_off_addr(input int unsigned dw);
    return dw;
  endfunction

  function automatic int unsigned seq_off_burst(input int unsigned aw, input int unsigned dw);
    return aw + dw;
  endfunction

  function automatic int unsigned seq_off_rd(input int unsigned bw, input int unsigned aw,
                                             input int unsigned dw);
    return bw + aw + dw;
  endfunction

  function automatic int unsigned seq_off_mask(input int unsigned bw, input int unsigned aw,
                                               input int unsigned dw);
    return bw + aw + dw + 1;
  endfunction

  function automatic int unsigned seq_off_last(input int unsigned nm, input int unsigned bw,
                                               input int unsigned aw, input int unsigned dw);
    return nm + bw + aw + dw + 1;
  endfunction

  function automatic int unsigned seq_entry_w(input int unsigned nm, input int unsigned bw,
                                              input int unsigned aw, input int unsigned dw);
    return nm + bw + aw + dw + 2;
  endfunction

endpackage

// File: rtl/bus_scenario_sequencer_if.sv
// Master-port bundle between the scenario sequencer (master modport) and the
// bus masters it drives (slave modport).
interface bus_scenario_sequencer_if #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned BURST_W     = 3
);
  logic [NUM_MASTERS-1:0]         m_request;
  logic [NUM_MASTERS-1:0]         m_enable;
  logic [NUM_MASTERS-1:0]         m_read_en;
  logic [NUM_MASTERS*BURST_W-1:0] m_burst_mode;
  logic [NUM_MASTERS*ADDR_W-1:0]  m_addr;
  logic [NUM_MASTERS*DATA_W-1:0]  m_data;

  modport master (
    input  m_request,
    output m_enable, m_read_en, m_burst_mode, m_addr, m_data
  );

  modport slave (
    output m_request,
    input  m_enable, m_read_en, m_burst_mode, m_addr, m_data
  );
endinterface

// File: rtl/bus_seq_table.sv
// Step table: one write port, one synchronous read port; a same-cycle read of
// the entry being written returns the previous contents. Not reset.
module bus_seq_table #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6,
  parameter int unsigned W     = 29
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    rdata_q <= mem_q[raddr_i];
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/bus_scenario_sequencer.sv
// Table-driven multi-step traffic generator for the bus masters.
// Optional WAIT-state abort: define BUS_SEQ_TIMEOUT_EN.
module bus_scenario_sequencer
  import bus_seq_pkg::*;
#(
  parameter  int unsigned NUM_MASTERS = 2,
  parameter  int unsigned ADDR_W      = 14,
  parameter  int unsigned DATA_W      = 8,
  parameter  int unsigned BURST_W     = 3,
  parameter  int unsigned NUM_SCEN    = 16,
  parameter  int unsigned STEPS       = 4,
  parameter  int unsigned EN_CYCLES   = 3,
  parameter  int unsigned TIMEOUT     = 255,
  localparam int unsigned SCEN_W      = seq_log2(NUM_SCEN),
  localparam int unsigned STEP_W      = seq_log2(STEPS),
  localparam int unsigned TBL_AW      = SCEN_W + STEP_W,
  localparam int unsigned ENTRY_W     = seq_entry_w(NUM_MASTERS, BURST_W, ADDR_W, DATA_W)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [SCEN_W-1:0]        scen_sel,
  input  logic                     tbl_we,
  input  logic [TBL_AW-1:0]        tbl_addr,
  input  logic [ENTRY_W-1:0]       tbl_wdata,
  bus_scenario_sequencer_if.master bus_if,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout_err,
  output logic [2:0]               state_out
);
  localparam int unsigned DEPTH     = NUM_SCEN * STEPS;
  localparam int unsigned OFF_ADDR  = seq_off_addr(DATA_W);
  localparam int unsigned OFF_BURST = seq_off_burst(ADDR_W, DATA_W);
  localparam int unsigned OFF_RD    = seq_off_rd(BURST_W, ADDR_W, DATA_W);
  localparam int unsigned OFF_MASK  = seq_off_mask(BURST_W, ADDR_W, DATA_W);
  localparam int unsigned OFF_LAST  = seq_off_last(NUM_MASTERS, BURST_W, ADDR_W, DATA_W);
  localparam int unsigned EN_W      = seq_log2(EN_CYCLES);

  seq_state_e                     state_q;
  logic [SCEN_W-1:0]              scen_q;
  logic [STEP_W-1:0]              step_q;
  logic                           last_q;
  logic [EN_W-1:0]                en_cnt_q;
  logic                           busy_q;
  logic                           done_q;
  logic [NUM_MASTERS-1:0]         m_enable_q;
  logic [NUM_MASTERS-1:0]         m_read_en_q;
  logic [NUM_MASTERS*BURST_W-1:0] m_burst_q;
  logic [NUM_MASTERS*ADDR_W-1:0]  m_addr_q;
  logic [NUM_MASTERS*DATA_W-1:0]  m_data_q;

  logic [TBL_AW-1:0]      rd_addr_d;
  logic [ENTRY_W-1:0]     rd_data;
  logic                   ld_last;
  logic [NUM_MASTERS-1:0] ld_mask;
  logic                   ld_rd;
  logic [BURST_W-1:0]     ld_burst;
  logic [ADDR_W-1:0]      ld_addr;
  logic [DATA_W-1:0]      ld_data;

  // The read address runs one state ahead so the entry sits on the RAM output during LOAD.
  always_comb begin
    if (state_q == ST_IDLE) rd_addr_d = {scen_sel, STEP_W'(0)};
    else                    rd_addr_d = {scen_q, STEP_W'(step_q + 1'b1)};
  end

  bus_seq_table #(
    .DEPTH(DEPTH),
    .AW   (TBL_AW),
    .W    (ENTRY_W)
  ) u_table (
    .clk_i  (clk),
    .we_i   (tbl_we & ~busy_q),
    .waddr_i(tbl_addr),
    .wdata_i(tbl_wdata),
    .raddr_i(rd_addr_d),
    .rdata_o(rd_data)
  );

  assign ld_last  = rd_data[OFF_LAST];
  assign ld_mask  = rd_data[OFF_MASK +: NUM_MASTERS];
  assign ld_rd    = rd_data[OFF_RD];
  assign ld_burst = rd_data[OFF_BURST +: BURST_W];
  assign ld_addr  = rd_data[OFF_ADDR +: ADDR_W];
  assign ld_data  = rd_data[0 +: DATA_W];

`ifdef BUS_SEQ_TIMEOUT_EN
  localparam int unsigned WAIT_W = seq_log2(TIMEOUT);
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              terr_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      scen_q      <= '0;
      step_q      <= '0;
      last_q      <= 1'b0;
      en_cnt_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      m_enable_q  <= '0;
      m_read_en_q <= '0;
      m_burst_q   <= '0;
      m_addr_q    <= '0;
      m_data_q    <= '0;
`ifdef BUS_SEQ_TIMEOUT_EN
      wait_cnt_q  <= '0;
      terr_q      <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            scen_q  <= scen_sel;
            step_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_LOAD;
`ifdef BUS_SEQ_TIMEOUT_EN
            terr_q  <= 1'b0;
`endif
          end
        end
        ST_LOAD: begin
          last_q <= ld_last;
          if (ld_mask == '0) begin
            state_q <= ST_NEXT;
          end else begin
            m_enable_q <= ld_mask;
            en_cnt_q   <= '0;
            state_q    <= ST_ISSUE;
            for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
              if (ld_mask[i]) begin
                m_read_en_q[i]                    <= ld_rd;
                m_burst_q[i*BURST_W +: BURST_W]   <= ld_burst;
                m_addr_q[i*ADDR_W +: ADDR_W]      <= ld_addr + ADDR_W'(i);
                m_data_q[i*DATA_W +: DATA_W]      <= ld_data + DATA_W'(i);
              end else begin
                m_read_en_q[i]                    <= 1'b0;
                m_burst_q[i*BURST_W +: BURST_W]   <= '0;
                m_addr_q[i*ADDR_W +: ADDR_W]      <= '0;
                m_data_q[i*DATA_W +: DATA_W]      <= '0;
              end
            end
          end
        end
        ST_ISSUE: begin
          if (en_cnt_q == EN_W'(EN_CYCLES - 1)) begin
            m_enable_q <= '0;
            state_q    <= ST_WAIT;
`ifdef BUS_SEQ_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
          end else begin
            en_cnt_q <= en_cnt_q + 1'b1;
          end
        end
        ST_WAIT: begin
          if (bus_if.m_request == '0) begin
            state_q <= ST_NEXT;
          end
`ifdef BUS_SEQ_TIMEOUT_EN
          else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
            terr_q      <= 1'b1;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            m_read_en_q <= '0;
            m_burst_q   <= '0;
            m_addr_q    <= '0;
            m_data_q    <= '0;
            state_q     <= ST_DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
`endif
        end
        ST_NEXT: begin
          if (last_q || step_q == STEP_W'(STEPS - 1)) begin
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            m_read_en_q <= '0;
            m_burst_q   <= '0;
            m_addr_q    <= '0;
            m_data_q    <= '0;
            state_q     <= ST_DONE;
          end else begin
            step_q  <= step_q + 1'b1;
            state_q <= ST_LOAD;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef BUS_SEQ_TIMEOUT_EN
  assign timeout_err = terr_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |32'(TIMEOUT);
  assign timeout_err        = 1'b0;
`endif

  assign bus_if.m_enable     = m_enable_q;
  assign bus_if.m_read_en    = m_read_en_q;
  assign bus_if.m_burst_mode = m_burst_q;
  assign bus_if.m_addr       = m_addr_q;
  assign bus_if.m_data       = m_data_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign state_out           = state_q;
endmodule
